// File: rtl/enc_pkg.sv
// Shared definitions for the registered 8-to-3 priority encoder.
// Holds the FSM state encoding, the fixed widths and the one-hot index helper.
package enc_pkg;

    localparam int NUM_REQ = 8;
    localparam int IDX_W   = 3;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_PRESENT = 1'b1
    } state_t;

    // One-hot mask selecting request line idx; used to retire an accepted code.
    function automatic logic [NUM_REQ-1:0] idx_mask(input logic [IDX_W-1:0] idx);
        logic [NUM_REQ-1:0] one_s;
        one_s    = {{(NUM_REQ-1){1'b0}}, 1'b1};
        idx_mask = one_s << idx;
    endfunction

endpackage

// File: rtl/prio8_3.sv
// Combinational 8-to-3 priority encoder: index of the highest set bit plus a
// non-zero flag. The index reads 0 when the input is all zero.
module prio8_3
    import enc_pkg::*;
(
    input  logic [NUM_REQ-1:0] i_vec,
    output logic [IDX_W-1:0]   o_idx,
    output logic               o_nz
);

    // Highest set bit wins; bit 7 has top priority.
    always_comb begin
        o_idx = 3'd0;
        o_nz  = |i_vec;
        casez (i_vec)
            8'b1???_????: o_idx = 3'd7;
            8'b01??_????: o_idx = 3'd6;
            8'b001?_????: o_idx = 3'd5;
            8'b0001_????: o_idx = 3'd4;
            8'b0000_1???: o_idx = 3'd3;
            8'b0000_01??: o_idx = 3'd2;
            8'b0000_001?: o_idx = 3'd1;
            8'b0000_0001: o_idx = 3'd0;
            default:      o_idx = 3'd0;
        endcase
    end

endmodule

// File: rtl/encoder8_3_seq_alw.sv
// Registered 8-to-3 priority encoder with pending-request capture and a
// valid/ready output. Define ENCODER_EDGE_CAPTURE_EN for rising-edge capture.
module encoder8_3_seq_alw
    import enc_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic D0,
    input  logic D1,
    input  logic D2,
    input  logic D3,
    input  logic D4,
    input  logic D5,
    input  logic D6,
    input  logic D7,
    input  logic ready,
    output logic A,
    output logic B,
    output logic C,
    output logic valid,
    output logic any
);

    logic [NUM_REQ-1:0] w_req;
    logic [NUM_REQ-1:0] w_cap;
    logic [NUM_REQ-1:0] w_set;
    logic [NUM_REQ-1:0] w_clr;
    logic [NUM_REQ-1:0] w_pend_nxt;
    logic [NUM_REQ-1:0] r_pend;
    logic [IDX_W-1:0]   w_prio_idx;
    logic [IDX_W-1:0]   w_code_nxt;
    logic [IDX_W-1:0]   r_code;
    logic               w_prio_nz;
    logic               w_valid_nxt;
    logic               r_valid;
    logic               r_any;
    state_t             w_state_nxt;
    state_t             r_state;

    assign w_req = {D7, D6, D5, D4, D3, D2, D1, D0};

`ifdef ENCODER_EDGE_CAPTURE_EN
    logic [NUM_REQ-1:0] r_req_q;

    // Edge history: previous sample of every request line.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_req_q <= {NUM_REQ{1'b0}};
        end else begin
            r_req_q <= w_req;
        end
    end

    assign w_cap = w_req & ~r_req_q;
`else
    assign w_cap = w_req;
`endif

    prio8_3 u_prio (
        .i_vec (r_pend),
        .o_idx (w_prio_idx),
        .o_nz  (w_prio_nz)
    );

    // Pending set update; a capture on the accept edge overrides the retire.
    always_comb begin
        w_set = {NUM_REQ{1'b0}};
        w_clr = {NUM_REQ{1'b0}};
        if (en) begin
            w_set = w_cap;
        end else begin
            w_set = {NUM_REQ{1'b0}};
        end
        if (r_valid && ready) begin
            w_clr = idx_mask(r_code);
        end else begin
            w_clr = {NUM_REQ{1'b0}};
        end
        w_pend_nxt = (r_pend & ~w_clr) | w_set;
    end

    // Next-state and next-output logic of the presentation FSM.
    always_comb begin
        w_state_nxt = r_state;
        w_code_nxt  = r_code;
        w_valid_nxt = r_valid;
        case (r_state)
            ST_IDLE: begin
                if (en && w_prio_nz) begin
                    w_state_nxt = ST_PRESENT;
                    w_code_nxt  = w_prio_idx;
                    w_valid_nxt = 1'b1;
                end else begin
                    w_state_nxt = ST_IDLE;
                    w_valid_nxt = 1'b0;
                end
            end
            ST_PRESENT: begin
                if (ready) begin
                    w_state_nxt = ST_IDLE;
                    w_valid_nxt = 1'b0;
                end else begin
                    w_state_nxt = ST_PRESENT;
                    w_valid_nxt = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_valid_nxt = 1'b0;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Pending set, presented code and status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pend  <= {NUM_REQ{1'b0}};
            r_code  <= {IDX_W{1'b0}};
            r_valid <= 1'b0;
            r_any   <= 1'b0;
        end else begin
            r_pend  <= w_pend_nxt;
            r_code  <= w_code_nxt;
            r_valid <= w_valid_nxt;
            r_any   <= |w_pend_nxt;
        end
    end

    assign A     = r_code[2];
    assign B     = r_code[1];
    assign C     = r_code[0];
    assign valid = r_valid;
    assign any   = r_any;

endmodule

// File: tb/tb_encoder8_3_seq_alw.sv
// Self-checking bench for encoder8_3_seq_alw: directed scenarios with literal
// expectations plus a randomized phase checked every cycle against a model.
module tb_encoder8_3_seq_alw;

    logic       clk = 1'b0;
    logic       rst;
    logic       en = 1'b1;
    logic       ready = 1'b1;
    logic [7:0] d = 8'h00;
    logic       A, B, C, valid, any;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    encoder8_3_seq_alw dut (
        .clk(clk), .rst(rst), .en(en),
        .D0(d[0]), .D1(d[1]), .D2(d[2]), .D3(d[3]),
        .D4(d[4]), .D5(d[5]), .D6(d[6]), .D7(d[7]),
        .ready(ready), .A(A), .B(B), .C(C), .valid(valid), .any(any)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int highest(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) begin
            if (v[i]) return i;
        end
        return 0;
    endfunction

    // Behavioural model: a set of pending request numbers and the code on offer.
    logic [7:0] m_pend = 8'h00;
    logic [7:0] m_prev = 8'h00;
    logic       m_valid = 1'b0;
    logic       m_any = 1'b0;
    int         m_code = 0;
    logic [7:0] t_nxt;
    bit         t_cap;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_pend = 8'h00; m_prev = 8'h00; m_valid = 1'b0; m_code = 0; m_any = 1'b0;
        end else begin
            t_nxt = m_pend;
            if (m_valid && ready) t_nxt[m_code] = 1'b0;
            for (int i = 0; i < 8; i++) begin
`ifdef ENCODER_EDGE_CAPTURE_EN
                t_cap = d[i] && !m_prev[i];
`else
                t_cap = d[i];
`endif
                if (en && t_cap) t_nxt[i] = 1'b1;
            end
            if (m_valid) begin
                if (ready) m_valid = 1'b0;
            end else if (en && m_pend != 8'h00) begin
                m_code  = highest(m_pend);
                m_valid = 1'b1;
            end
            m_prev = d;
            m_pend = t_nxt;
            m_any  = (t_nxt != 8'h00);
        end
    end

    // Per-cycle compare plus a log of each newly presented code.
    int  seen[$];
    int  seen_cyc[$];
    int  vcount = 0;
    logic prev_valid = 1'b0;

    always @(negedge clk) begin
        cyc++;
        chk("valid", int'(valid), int'(m_valid));
        chk("any", int'(any), int'(m_any));
        if (m_valid) chk("abc", int'({A, B, C}), m_code);
        if (valid && !prev_valid) begin
            seen.push_back(int'({A, B, C}));
            seen_cyc.push_back(cyc);
        end
        if (valid) vcount++;
        prev_valid = valid;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            #2;
        end
    endtask

    task automatic clear_log();
        seen.delete();
        seen_cyc.delete();
        vcount = 0;
    endtask

    task automatic chk_seen(input string name, input int n, input int e0, input int e1, input int e2);
        int exp_v[3];
        exp_v[0] = e0; exp_v[1] = e1; exp_v[2] = e2;
        chk({name, "_count"}, seen.size(), n);
        for (int i = 0; i < n && i < 3; i++) begin
            chk({name, "_code"}, (i < seen.size()) ? seen[i] : -1, exp_v[i]);
        end
    endtask

    initial begin
        rst = 1'b1;
        tick(2);
        chk("reset_abc", int'({A, B, C}), 0);
        chk("reset_valid", int'(valid), 0);
        chk("reset_any", int'(any), 0);
        rst = 1'b0;
        tick(2);

        // Single request on D3.
        clear_log();
        d = 8'h08; tick(1); d = 8'h00;
        tick(6);
        chk_seen("single", 1, 3, 0, 0);
        chk("single_vcycles", vcount, 1);
        chk("single_any_after", int'(any), 0);

        // D1, D4, D6 together: 6, 4, 1 with one-cycle gaps.
        clear_log();
        d = 8'h52; tick(1); d = 8'h00;
        tick(10);
        chk_seen("prio", 3, 6, 4, 1);
        chk("prio_vcycles", vcount, 3);
        if (seen_cyc.size() == 3) begin
            chk("prio_gap0", seen_cyc[1] - seen_cyc[0], 2);
            chk("prio_gap1", seen_cyc[2] - seen_cyc[1], 2);
        end

        // Backpressure: code 2 held while D7 arrives.
        clear_log();
        ready = 1'b0;
        d = 8'h04; tick(1); d = 8'h00;
        tick(2);
        d = 8'h80; tick(1); d = 8'h00;
        tick(3);
        chk("hold_abc", int'({A, B, C}), 2);
        chk("hold_valid", int'(valid), 1);
        ready = 1'b1;
        tick(6);
        chk_seen("hold", 2, 2, 7, 0);

        // Re-request D2 on its own accept edge.
        clear_log();
        ready = 1'b0;
        d = 8'h04; tick(1); d = 8'h00;
        tick(2);
        ready = 1'b1; d = 8'h04; tick(1); d = 8'h00;
        tick(6);
        chk_seen("collide", 2, 2, 2, 0);

        // en=0 blocks capture of D0.
        clear_log();
        en = 1'b0;
        d = 8'h01; tick(1); d = 8'h00;
        tick(2);
        en = 1'b1;
        tick(6);
        chk("en_off_count", seen.size(), 0);
        chk("en_off_any", int'(any), 0);

        // D5 held for 10 cycles.
        clear_log();
        d = 8'h20; tick(10); d = 8'h00;
        tick(6);
`ifdef ENCODER_EDGE_CAPTURE_EN
        chk_seen("held", 1, 5, 0, 0);
`else
        chk("held_count", seen.size(), 5);
        for (int i = 0; i < seen.size(); i++) chk("held_code", seen[i], 5);
        for (int i = 1; i < seen_cyc.size(); i++) chk("held_gap", seen_cyc[i] - seen_cyc[i-1], 2);
`endif

        // Reset mid-presentation of code 5.
        clear_log();
        ready = 1'b0;
        d = 8'h20; tick(1); d = 8'h00;
        tick(2);
        chk("pre_rst_abc", int'({A, B, C}), 5);
        chk("pre_rst_valid", int'(valid), 1);
        rst = 1'b1;
        #1;
        chk("mid_rst_abc", int'({A, B, C}), 0);
        chk("mid_rst_valid", int'(valid), 0);
        chk("mid_rst_any", int'(any), 0);
        tick(1);
        rst = 1'b0;
        ready = 1'b1;
        clear_log();
        tick(6);
        chk("post_rst_count", seen.size(), 0);

        // Randomized traffic checked cycle by cycle against the model.
        for (int n = 0; n < 600; n++) begin
            d     = 8'($urandom & $urandom & $urandom);
            en    = ($urandom_range(0, 9) != 0);
            ready = ($urandom_range(0, 2) != 0);
            rst   = ($urandom_range(0, 149) == 0);
            tick(1);
        end
        rst = 1'b0; d = 8'h00; en = 1'b1; ready = 1'b1;
        tick(20);
        chk("drain_any", int'(any), 0);
        chk("drain_valid", int'(valid), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
